// File: rtl/cache_controller_pkg.sv
// Shared constants, state encoding and payload types for the 2-way
// write-through read cache.
package cache_controller_pkg;

    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned WORD_W       = 32;
    localparam int unsigned BLOCK_W      = 64;
    localparam int unsigned INDEX_W      = 6;
    localparam int unsigned TAG_W        = 10;
    localparam int unsigned WAYS         = 2;
    localparam int unsigned SET_COUNT    = 64;

    // Address field positions: addr[2] word select, addr[8:3] index, addr[18:9] tag.
    localparam int unsigned WORD_SEL_BIT = 2;
    localparam int unsigned INDEX_LSB    = 3;
    localparam int unsigned TAG_LSB      = INDEX_LSB + INDEX_W;

    localparam logic [1:0] ST_IDLE      = 2'b00;
    localparam logic [1:0] ST_READ_MISS = 2'b01;
    localparam logic [1:0] ST_WRITE     = 2'b10;

    typedef struct packed {
        logic               way;
        logic [TAG_W-1:0]   tag;
        logic [BLOCK_W-1:0] data;
    } fill_t;

    function automatic logic [WORD_W-1:0] word_sel(input logic [BLOCK_W-1:0] blk,
                                                   input logic              hi);
        return hi ? blk[BLOCK_W-1:WORD_W] : blk[WORD_W-1:0];
    endfunction

endpackage

// File: rtl/cache_controller_array.sv
// Tag/data/valid/lru storage for the 2-way cache: combinational lookup on one
// set, plus fill, invalidate and lru-update ports on that same set.
module cache_controller_array
    import cache_controller_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INDEX_W-1:0]   index,
    input  logic [TAG_W-1:0]     lookup_tag,
    output logic                 hit_c,
    output logic                 hit_way_c,
    output logic [BLOCK_W-1:0]   hit_data_c,
    output logic [WAYS-1:0]      way_valid_c,
    output logic                 lru_c,
    input  logic                 fill_en,
    input  fill_t                fill,
    input  logic                 inv_en,
    input  logic                 inv_way,
    input  logic                 lru_en,
    input  logic                 lru_val
);

    logic [WAYS-1:0][SET_COUNT-1:0] valid_q;
    logic [SET_COUNT-1:0]           lru_q;
    logic [TAG_W-1:0]               tag_q  [WAYS][SET_COUNT];
    logic [BLOCK_W-1:0]             data_q [WAYS][SET_COUNT];
    logic [WAYS-1:0]                hit_vec;

    // Lookup of the addressed set
    always_comb begin
        way_valid_c[0] = valid_q[0][index];
        way_valid_c[1] = valid_q[1][index];
        hit_vec[0]     = valid_q[0][index] && (tag_q[0][index] == lookup_tag);
        hit_vec[1]     = valid_q[1][index] && (tag_q[1][index] == lookup_tag);
        hit_c          = |hit_vec;
        hit_way_c      = hit_vec[1];
        hit_data_c     = hit_vec[1] ? data_q[1][index] : data_q[0][index];
        lru_c          = lru_q[index];
    end

    // Valid and lru bits are the only state that must clear on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            lru_q   <= '0;
        end else begin
            if (fill_en) begin
                valid_q[fill.way][index] <= 1'b1;
            end
            if (inv_en) begin
                valid_q[inv_way][index] <= 1'b0;
            end
            if (lru_en) begin
                lru_q[index] <= lru_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill.way][index]  <= fill.tag;
            data_q[fill.way][index] <= fill.data;
        end
    end

endmodule

// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate read cache between
// the MEM stage and the SRAM controller user port.
module cache_controller
    import cache_controller_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_en,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [WORD_W-1:0]    wdata,
    output logic [WORD_W-1:0]    rdata,
    output logic                 ready,
    output logic                 sram_rd_en,
    output logic                 sram_wr_en,
    output logic [ADDR_W-1:0]    sram_addr,
    output logic [WORD_W-1:0]    sram_wdata,
    input  logic [BLOCK_W-1:0]   sram_rdata,
    input  logic                 sram_ready
);

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [INDEX_W-1:0]  index;
    logic [TAG_W-1:0]    tag;
    logic                word_hi;
    logic                hit;
    logic                hit_way;
    logic [BLOCK_W-1:0]  hit_data;
    logic [WAYS-1:0]     way_valid;
    logic                lru_bit;
    logic                victim;
    logic                fill_en;
    logic                inv_en;
    logic                lru_en;
    logic                lru_val;
    fill_t               fill;

    assign index   = addr[INDEX_LSB +: INDEX_W];
    assign tag     = addr[TAG_LSB +: TAG_W];
    assign word_hi = addr[WORD_SEL_BIT];

    // Prefer an empty way before evicting the least recently used one
    assign victim = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_bit);

    always_comb begin
        fill.way  = victim;
        fill.tag  = tag;
        fill.data = sram_rdata;
    end

    cache_controller_array u_array (
        .clk         (clk),
        .rst         (rst),
        .index       (index),
        .lookup_tag  (tag),
        .hit_c       (hit),
        .hit_way_c   (hit_way),
        .hit_data_c  (hit_data),
        .way_valid_c (way_valid),
        .lru_c       (lru_bit),
        .fill_en     (fill_en),
        .fill        (fill),
        .inv_en      (inv_en),
        .inv_way     (hit_way),
        .lru_en      (lru_en),
        .lru_val     (lru_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // SRAM requests decode straight from state so a reset drops them at once
    always_comb begin
        state_nxt  = state;
        ready      = 1'b0;
        rdata      = '0;
        sram_rd_en = 1'b0;
        sram_wr_en = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        fill_en    = 1'b0;
        inv_en     = 1'b0;
        lru_en     = 1'b0;
        lru_val    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (wr_en) begin
                    // A write to a cached block drops that line; rd_en is ignored
                    state_nxt = ST_WRITE;
                    inv_en    = hit;
                end else if (rd_en) begin
                    if (hit) begin
                        ready   = 1'b1;
                        rdata   = word_sel(hit_data, word_hi);
                        lru_en  = 1'b1;
                        lru_val = ~hit_way;
                    end else begin
                        state_nxt = ST_READ_MISS;
                    end
                end else begin
                    ready = 1'b1;
                end
            end

            ST_READ_MISS: begin
                sram_rd_en = 1'b1;
                sram_addr  = {addr[ADDR_W-1:INDEX_LSB], {INDEX_LSB{1'b0}}};
                if (sram_ready) begin
                    ready     = 1'b1;
                    rdata     = word_sel(sram_rdata, word_hi);
                    fill_en   = 1'b1;
                    lru_en    = 1'b1;
                    lru_val   = ~victim;
                    state_nxt = ST_IDLE;
                end
            end

            ST_WRITE: begin
                sram_wr_en = 1'b1;
                sram_addr  = addr;
                sram_wdata = wdata;
                if (sram_ready) begin
                    ready     = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: directed requests against a recency-ordered
// residency model and a word-addressed SRAM model with a latency responder.
module tb_cache_controller;

    localparam int K_NONE  = 0;
    localparam int K_READ  = 1;
    localparam int K_WRITE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en, wr_en;
    logic [31:0] addr, wdata, rdata;
    logic        ready, sram_rd_en, sram_wr_en;
    logic [31:0] sram_addr, sram_wdata;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    always #5 clk = ~clk;

    cache_controller dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .sram_rd_en (sram_rd_en),
        .sram_wr_en (sram_wr_en),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_ready (sram_ready)
    );

    int          pass_cnt = 0;
    int          chk_cnt  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // SRAM contents, 64-bit block per key addr>>3
    logic [63:0] mem [int unsigned];

    function automatic logic [63:0] mem_rd(input logic [31:0] a);
        int unsigned k;
        logic [31:0] base;
        k    = 32'(a >> 3);
        base = a & 32'hFFFF_FFF8;
        if (mem.exists(k)) return mem[k];
        return {~base, base};
    endfunction

    // Cache model: resident blocks keyed by addr[18:3], with last-use time
    int unsigned stamp [int unsigned];
    logic [63:0] cdata [int unsigned];
    int unsigned now_t = 0;

    function automatic int unsigned mkey(input logic [31:0] a);
        return 32'(a[18:3]);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return stamp.exists(mkey(a));
    endfunction

    function automatic void model_touch(input logic [31:0] a);
        now_t++;
        stamp[mkey(a)] = now_t;
    endfunction

    function automatic void model_fill(input logic [31:0] a, input logic [63:0] d);
        int unsigned k, oldest_k, oldest_t, n;
        k = mkey(a);
        n = 0;
        oldest_k = 0;
        oldest_t = 32'hFFFF_FFFF;
        foreach (stamp[r]) begin
            if ((r % 64) == (k % 64)) begin
                n++;
                if (stamp[r] < oldest_t) begin
                    oldest_t = stamp[r];
                    oldest_k = r;
                end
            end
        end
        if (n >= 2) begin
            stamp.delete(oldest_k);
            cdata.delete(oldest_k);
        end
        cdata[k] = d;
        model_touch(a);
    endfunction

    function automatic void model_inv(input logic [31:0] a);
        if (stamp.exists(mkey(a))) begin
            stamp.delete(mkey(a));
            cdata.delete(mkey(a));
        end
    endfunction

    // Shared request context read by the compare process
    int          cur_kind = K_NONE;
    int          cur_cycle = 0;
    bit          cur_hit = 1'b0;
    logic [31:0] cur_addr = '0;
    logic [31:0] cur_wdata = '0;
    logic [31:0] cur_exp = '0;

    // SRAM responder: completes in the lat-th cycle of a request burst
    int          lat = 3;
    bit          idle_noise = 1'b0;
    logic [31:0] last_rd_addr = '0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wdata = '0;

    initial begin
        int cnt;
        logic [63:0] blk;
        cnt = 0;
        sram_ready = 1'b0;
        sram_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (sram_rd_en || sram_wr_en) begin
                cnt++;
                sram_ready = (cnt == lat);
                if (cnt == lat) begin
                    if (sram_wr_en) begin
                        blk = mem_rd(sram_addr);
                        if (sram_addr[2]) blk[63:32] = sram_wdata;
                        else blk[31:0] = sram_wdata;
                        mem[32'(sram_addr >> 3)] = blk;
                        last_wr_addr = sram_addr;
                        last_wdata   = sram_wdata;
                    end else begin
                        sram_rdata   = mem_rd(sram_addr);
                        last_rd_addr = sram_addr;
                    end
                end
            end else begin
                cnt = 0;
                sram_ready = idle_noise;
            end
        end
    end

    // Compare process: every cycle outside reset
    int rd_bursts = 0;
    initial begin
        logic prev_rd;
        prev_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_rd = 1'b0;
                continue;
            end
            if (sram_rd_en && !prev_rd) rd_bursts++;
            prev_rd = sram_rd_en;
            if (cur_kind == K_NONE) begin
                chk("idle_ready", 64'(ready), 64'd1);
                chk("idle_sram_req", 64'({sram_rd_en, sram_wr_en}), 64'd0);
                chk("idle_rdata", 64'(rdata), 64'd0);
            end else if (cur_cycle == 0) begin
                chk("req0_sram_req", 64'({sram_rd_en, sram_wr_en}), 64'd0);
                chk("req0_ready", 64'(ready), 64'((cur_kind == K_READ) && cur_hit));
                chk("req0_rdata", 64'(rdata),
                    64'(((cur_kind == K_READ) && cur_hit) ? cur_exp : 32'd0));
            end else if (cur_kind == K_READ) begin
                chk("miss_sram_rd_en", 64'({sram_rd_en, sram_wr_en}), 64'd2);
                chk("miss_sram_addr", 64'(sram_addr), 64'(cur_addr & 32'hFFFF_FFF8));
                chk("miss_ready", 64'(ready), 64'(sram_ready));
                chk("miss_rdata", 64'(rdata), 64'(sram_ready ? cur_exp : 32'd0));
            end else begin
                chk("wr_sram_wr_en", 64'({sram_rd_en, sram_wr_en}), 64'd1);
                chk("wr_sram_addr", 64'(sram_addr), 64'(cur_addr));
                chk("wr_sram_wdata", 64'(sram_wdata), 64'(cur_wdata));
                chk("wr_ready", 64'(ready), 64'(sram_ready));
            end
        end
    end

    // Issue one request at posedge+1; returns at the posedge+1 after completion
    task automatic do_req(input int kind, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] got, output int low);
        logic [63:0] blk;
        addr      = a;
        wdata     = wd;
        rd_en     = (kind == K_READ);
        wr_en     = (kind == K_WRITE);
        cur_addr  = a;
        cur_wdata = wd;
        cur_cycle = 0;
        cur_hit   = model_hit(a);
        blk       = cur_hit ? cdata[mkey(a)] : mem_rd(a);
        cur_exp   = a[2] ? blk[63:32] : blk[31:0];
        cur_kind  = kind;
        got       = '0;
        forever begin
            @(negedge clk);
            #1;
            if (ready) begin
                got = rdata;
                break;
            end
            if (cur_cycle >= 60) begin
                chk("req_timeout_ready", 64'(ready), 64'd1);
                break;
            end
            @(posedge clk);
            #1;
            cur_cycle++;
        end
        low = cur_cycle;
        if (kind == K_READ) begin
            if (cur_hit) model_touch(a);
            else model_fill(a, blk);
        end else begin
            model_inv(a);
        end
        @(posedge clk);
        #1;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        cur_kind = K_NONE;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] got;
        int          low;
        int          b0;
        rd_en = 1'b0;
        wr_en = 1'b0;
        addr  = '0;
        wdata = '0;
        mem[32'h80] = 64'hBBBB_BBBB_AAAA_AAAA;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_ready", 64'(ready), 64'd1);
        chk("reset_sram_rd_en", 64'(sram_rd_en), 64'd0);
        chk("reset_sram_wr_en", 64'(sram_wr_en), 64'd0);
        chk("reset_rdata", 64'(rdata), 64'd0);
        @(posedge clk);
        #1;

        // Cold miss then back-to-back hit on the other word
        lat = 5;
        do_req(K_READ, 32'h0000_0404, '0, got, low);
        chk("cold_rdata", 64'(got), 64'hBBBB_BBBB);
        chk("cold_ready_low", 64'(low), 64'd5);
        chk("cold_sram_addr", 64'(last_rd_addr), 64'h400);
        chk("cold_bursts", 64'(rd_bursts), 64'd1);
        do_req(K_READ, 32'h0000_0400, '0, got, low);
        chk("hit_rdata", 64'(got), 64'hAAAA_AAAA);
        chk("hit_ready_low", 64'(low), 64'd0);
        chk("hit_no_burst", 64'(rd_bursts), 64'd1);

        // Write hit invalidates; write-through reaches SRAM
        lat = 3;
        do_req(K_WRITE, 32'h0000_0404, 32'h0000_1234, got, low);
        chk("wr_addr", 64'(last_wr_addr), 64'h404);
        chk("wr_data", 64'(last_wdata), 64'h1234);
        chk("wr_ready_low", 64'(low), 64'd3);
        do_req(K_READ, 32'h0000_0404, '0, got, low);
        chk("rd_after_wr_low", 64'(low), 64'd3);
        chk("rd_after_wr_rdata", 64'(got), 64'h1234);
        chk("rd_after_wr_bursts", 64'(rd_bursts), 64'd2);

        // Reset two cycles into a miss
        lat = 20;
        addr = 32'h0000_0600;
        rd_en = 1'b1;
        cur_addr = 32'h0000_0600;
        cur_cycle = 0;
        cur_hit = model_hit(32'h0000_0600);
        cur_exp = '0;
        cur_kind = K_READ;
        chk("model_600_miss", 64'(cur_hit), 64'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            cur_cycle++;
        end
        @(negedge clk);
        #2;
        chk("pre_rst_sram_rd_en", 64'(sram_rd_en), 64'd1);
        rst = 1'b1;
        rd_en = 1'b0;
        cur_kind = K_NONE;
        #1;
        chk("rst_drops_sram_rd_en", 64'(sram_rd_en), 64'd0);
        chk("rst_ready", 64'(ready), 64'd1);
        stamp.delete();
        cdata.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        lat = 3;
        b0 = rd_bursts;
        do_req(K_READ, 32'h0000_0404, '0, got, low);
        chk("post_rst_miss_low", 64'(low), 64'd3);
        chk("post_rst_burst", 64'(rd_bursts - b0), 64'd1);

        // LRU: 0x400 must evict 0x200 after 0x000 is touched
        do_req(K_READ, 32'h0000_0000, '0, got, low);
        do_req(K_READ, 32'h0000_0200, '0, got, low);
        chk("fill_200_rdata", 64'(got), 64'h200);
        do_req(K_READ, 32'h0000_0000, '0, got, low);
        chk("lru_hit_000_low", 64'(low), 64'd0);
        do_req(K_READ, 32'h0000_0400, '0, got, low);
        chk("lru_miss_400_low", 64'(low), 64'd3);
        do_req(K_READ, 32'h0000_0000, '0, got, low);
        chk("lru_rehit_000_low", 64'(low), 64'd0);
        do_req(K_READ, 32'h0000_0200, '0, got, low);
        chk("lru_evicted_200_low", 64'(low), 64'd3);

        // Write miss does not allocate
        do_req(K_WRITE, 32'h0000_0800, 32'h0000_0055, got, low);
        do_req(K_READ, 32'h0000_0800, '0, got, low);
        chk("wmiss_read_low", 64'(low), 64'd3);
        chk("wmiss_read_rdata", 64'(got), 64'h55);

        // Responder claims ready while idle: must not be taken as completion
        idle_noise = 1'b1;
        idle(3);
        b0 = rd_bursts;
        do_req(K_READ, 32'h0000_1008, '0, got, low);
        chk("noise_miss_burst", 64'(rd_bursts - b0), 64'd1);
        chk("noise_miss_low", 64'(low), 64'd3);
        do_req(K_READ, 32'h0000_100C, '0, got, low);
        chk("noise_hit_rdata", 64'(got), 64'hFFFF_EFF7);
        do_req(K_WRITE, 32'h0000_1010, 32'hCAFE_0001, got, low);
        chk("noise_wr_low", 64'(low), 64'd3);
        idle(2);
        do_req(K_READ, 32'h0000_2000, '0, got, low);
        chk("noise_second_burst", 64'(rd_bursts - b0), 64'd2);
        idle_noise = 1'b0;
        idle(3);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
